// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte streams around the frame controller: receiver bytes in, verified
// payload bytes out over valid/ready.
interface uart_rx_frame_ctrl_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       s_tick;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    // The frame controller consumes receiver bytes and sources the payload stream.
    modport slave (
        input  rx_done_tick,
        input  rx_data,
        input  s_tick,
        input  m_ready,
        output m_data,
        output m_valid,
        output m_last
    );

    modport master (
        output rx_done_tick,
        output rx_data,
        output s_tick,
        output m_ready,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Packet framer behind the UART receiver: hunts for sync, checks length and
// XOR checksum, and releases only verified payloads downstream.
module uart_rx_frame_ctrl #(
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         TIMEOUT_TICKS = 320
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_frame_ctrl_if.slave   bus,
    output logic                  pkt_ok,
    output logic                  err_chk,
    output logic                  err_len,
    output logic                  err_tmo,
    output logic                  err_ovr,
    output logic                  busy
);
    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int BUF_AW = $clog2(MAX_LEN);
    localparam int TMO_W  = $clog2(TIMEOUT_TICKS);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t           state_q;
    logic [7:0]       buf_q [MAX_LEN];
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [7:0]       chk_acc_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [7:0]       m_data_q;
    logic             m_valid_q;
    logic             m_last_q;
    logic             pkt_ok_q;
    logic             err_chk_q;
    logic             err_len_q;
    logic             err_tmo_q;
    logic             err_ovr_q;
    logic             busy_q;

    logic [IDX_W-1:0] len_m1;
    logic [IDX_W-1:0] rd_next;
    logic             len_ok;
    logic             tmo_expire;

    assign len_m1     = len_q - IDX_W'(1);
    assign rd_next    = rd_idx_q + IDX_W'(1);
    assign len_ok     = (bus.rx_data != 8'h00) && (bus.rx_data <= 8'(MAX_LEN));
    assign tmo_expire = bus.s_tick && (tmo_cnt_q == TMO_W'(TIMEOUT_TICKS - 1));

    // Payload storage needs no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (state_q == PAYLOAD && bus.rx_done_tick) begin
            buf_q[wr_idx_q[BUF_AW-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            len_q     <= '0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            chk_acc_q <= '0;
            tmo_cnt_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            pkt_ok_q  <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            pkt_ok_q  <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (bus.rx_done_tick && bus.rx_data == SYNC_BYTE) begin
                        state_q   <= LEN;
                        busy_q    <= 1'b1;
                        tmo_cnt_q <= '0;
                    end
                end
                LEN, PAYLOAD, CHK: begin
                    // A byte arriving with the expiring tick takes priority over the timeout.
                    if (bus.rx_done_tick) begin
                        tmo_cnt_q <= '0;
                        if (state_q == LEN) begin
                            if (len_ok) begin
                                len_q     <= bus.rx_data[IDX_W-1:0];
                                chk_acc_q <= bus.rx_data;
                                wr_idx_q  <= '0;
                                state_q   <= PAYLOAD;
                            end else begin
                                err_len_q <= 1'b1;
                                state_q   <= HUNT;
                                busy_q    <= 1'b0;
                            end
                        end else if (state_q == PAYLOAD) begin
                            chk_acc_q <= chk_acc_q ^ bus.rx_data;
                            wr_idx_q  <= wr_idx_q + IDX_W'(1);
                            if (wr_idx_q == len_m1) begin
                                state_q <= CHK;
                            end
                        end else begin
                            if (bus.rx_data == chk_acc_q) begin
                                pkt_ok_q  <= 1'b1;
                                rd_idx_q  <= '0;
                                m_valid_q <= 1'b1;
                                m_data_q  <= buf_q[0];
                                m_last_q  <= (len_q == IDX_W'(1));
                                state_q   <= DRAIN;
                            end else begin
                                err_chk_q <= 1'b1;
                                state_q   <= HUNT;
                                busy_q    <= 1'b0;
                            end
                        end
                    end else if (bus.s_tick) begin
                        if (tmo_expire) begin
                            err_tmo_q <= 1'b1;
                            state_q   <= HUNT;
                            busy_q    <= 1'b0;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The single buffer is still in use, so every new byte is dropped.
                    if (bus.rx_done_tick) begin
                        err_ovr_q <= 1'b1;
                    end
                    if (m_valid_q && bus.m_ready) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            m_data_q  <= '0;
                            state_q   <= HUNT;
                            busy_q    <= 1'b0;
                        end else begin
                            rd_idx_q <= rd_next;
                            m_data_q <= buf_q[rd_next[BUF_AW-1:0]];
                            m_last_q <= (rd_next == len_m1);
                        end
                    end
                end
                default: begin
                    state_q <= HUNT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign pkt_ok      = pkt_ok_q;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_tmo     = err_tmo_q;
    assign err_ovr     = err_ovr_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: table of frames plus hand-written timeout,
// backpressure and reset sequences, with a scoreboard on the payload stream.
module tb_uart_rx_frame_ctrl;
    logic clk;
    logic rst_n;
    logic pkt_ok, err_chk, err_len, err_tmo, err_ovr, busy;

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl #(
        .MAX_LEN(16),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_TICKS(320)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .pkt_ok(pkt_ok),
        .err_chk(err_chk),
        .err_len(err_len),
        .err_tmo(err_tmo),
        .err_ovr(err_ovr),
        .busy(busy)
    );

    typedef struct {
        logic [63:0] data;
        int          n;
        int          payLen;
        int          expOk;
        int          expChk;
        int          expLen;
    } vec_t;

    vec_t       vecs[6];
    logic [8:0] expQ[$];
    int         errors = 0;
    int         checks = 0;
    int         okCnt = 0, chkCnt = 0, lenCnt = 0, tmoCnt = 0, ovrCnt = 0;
    int         validCycles = 0;

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples on the falling edge: counts pulses, scores handshakes, checks stall hold.
    task automatic monitorLoop();
        logic       prevStall = 1'b0;
        logic [7:0] prevData = '0;
        logic       prevLast = 1'b0;
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 1'b0;
                continue;
            end
            okCnt       += int'(pkt_ok);
            chkCnt      += int'(err_chk);
            lenCnt      += int'(err_len);
            tmoCnt      += int'(err_tmo);
            ovrCnt      += int'(err_ovr);
            validCycles += int'(bus.m_valid);
            if (prevStall) begin
                checkOutput("stall_hold", {22'd0, bus.m_valid, bus.m_last, bus.m_data},
                            {22'd0, 1'b1, prevLast, prevData});
            end
            if (bus.m_valid && bus.m_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL drain_unexpected: got byte %0h with no byte expected", bus.m_data);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("drain_byte", {23'd0, bus.m_last, bus.m_data}, {23'd0, exp});
                end
            end
            prevStall = bus.m_valid && !bus.m_ready;
            prevData  = bus.m_data;
            prevLast  = bus.m_last;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.rx_data      = b;
        bus.rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            bus.s_tick = 1'b1;
            @(posedge clk);
            #1;
            bus.s_tick = 1'b0;
        end
    endtask

    task automatic checkOutputsZero(input string name);
        checkOutput({name, "_data"}, {24'd0, bus.m_data}, 32'd0);
        checkOutput({name, "_stream"}, {30'd0, bus.m_valid, bus.m_last}, 32'd0);
        checkOutput({name, "_pulses"}, {27'd0, pkt_ok, err_chk, err_len, err_tmo, err_ovr}, 32'd0);
        checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Sends one table frame with m_ready high and checks the flag and stream tallies.
    task automatic applyStimulus(input int idx);
        int ok0 = okCnt, chk0 = chkCnt, len0 = lenCnt, tmo0 = tmoCnt, ovr0 = ovrCnt, val0 = validCycles;
        logic [7:0] b;
        if (vecs[idx].expOk != 0) begin
            for (int k = 2; k < vecs[idx].n - 1; k++) begin
                b = vecs[idx].data[8*(vecs[idx].n-1-k) +: 8];
                expQ.push_back({(k == vecs[idx].n - 2), b});
            end
        end
        for (int k = 0; k < vecs[idx].n; k++) begin
            sendByte(vecs[idx].data[8*(vecs[idx].n-1-k) +: 8]);
        end
        idle(vecs[idx].payLen + 4);
        checkOutput($sformatf("v%0d_pkt_ok", idx), okCnt - ok0, vecs[idx].expOk);
        checkOutput($sformatf("v%0d_err_chk", idx), chkCnt - chk0, vecs[idx].expChk);
        checkOutput($sformatf("v%0d_err_len", idx), lenCnt - len0, vecs[idx].expLen);
        checkOutput($sformatf("v%0d_err_tmo", idx), tmoCnt - tmo0, 0);
        checkOutput($sformatf("v%0d_err_ovr", idx), ovrCnt - ovr0, 0);
        checkOutput($sformatf("v%0d_valid_cycles", idx), validCycles - val0,
                    (vecs[idx].expOk != 0) ? vecs[idx].payLen : 0);
        checkOutput($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd0);
        checkOutput($sformatf("v%0d_sb_left", idx), expQ.size(), 0);
    endtask

    initial begin
        int         ok0, tmo0, ovr0, len0;
        logic [7:0] x;
        logic [7:0] chk;

        vecs[0] = '{64'hA5_03_11_22_33_03, 6, 3, 1, 0, 0};
        vecs[1] = '{64'hA5_02_AA_55_00,    5, 2, 0, 1, 0};
        vecs[2] = '{64'hA5_03_11_22_33_03, 6, 3, 1, 0, 0};
        vecs[3] = '{64'h00_FF_A5_00,       4, 0, 0, 0, 1};
        vecs[4] = '{64'hA5_11,             2, 0, 0, 0, 1};
        vecs[5] = '{64'hA5_01_5A_5B,       4, 1, 1, 0, 0};

        rst_n            = 1'b0;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.s_tick       = 1'b0;
        bus.m_ready      = 1'b1;

        fork
            monitorLoop();
        join_none

        idle(3);
        checkOutputsZero("reset");
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(i);
        end

        // Full-length payload at the MAX_LEN boundary.
        ok0 = okCnt;
        chk = 8'h10;
        sendByte(8'hA5);
        sendByte(8'h10);
        for (int i = 0; i < 16; i++) begin
            x = 8'(i * 17 + 1);
            chk ^= x;
            expQ.push_back({(i == 15), x});
            sendByte(x);
        end
        sendByte(chk);
        idle(20);
        checkOutput("maxlen_pkt_ok", okCnt - ok0, 1);
        checkOutput("maxlen_sb_left", expQ.size(), 0);

        // Inter-byte timeout expires on the 320th tick.
        tmo0 = tmoCnt;
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h7E);
        tick(319);
        checkOutput("tmo_early", tmoCnt - tmo0, 0);
        checkOutput("tmo_busy_wait", {31'd0, busy}, 32'd1);
        tick(1);
        idle(2);
        checkOutput("tmo_fire", tmoCnt - tmo0, 1);
        checkOutput("tmo_busy_after", {31'd0, busy}, 32'd0);

        // A byte landing on the expiring tick wins over the timeout.
        tmo0 = tmoCnt;
        ok0  = okCnt;
        expQ.push_back({1'b0, 8'h7E});
        expQ.push_back({1'b1, 8'h01});
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h7E);
        tick(319);
        bus.s_tick       = 1'b1;
        bus.rx_data      = 8'h01;
        bus.rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.s_tick       = 1'b0;
        bus.rx_done_tick = 1'b0;
        sendByte(8'h7D);
        idle(5);
        checkOutput("tmo_suppress", tmoCnt - tmo0, 0);
        checkOutput("tmo_suppress_ok", okCnt - ok0, 1);
        checkOutput("tmo_suppress_sb", expQ.size(), 0);

        // Toggling backpressure with a sync byte dropped during drain.
        ok0  = okCnt;
        ovr0 = ovrCnt;
        len0 = lenCnt;
        bus.m_ready = 1'b0;
        expQ.push_back({1'b0, 8'hDE});
        expQ.push_back({1'b0, 8'hAD});
        expQ.push_back({1'b0, 8'hBE});
        expQ.push_back({1'b1, 8'hEF});
        sendByte(8'hA5);
        sendByte(8'h04);
        sendByte(8'hDE);
        sendByte(8'hAD);
        sendByte(8'hBE);
        sendByte(8'hEF);
        sendByte(8'h26);
        for (int i = 0; i < 12; i++) begin
            bus.m_ready = ((i % 2) == 0);
            if (i == 1) begin
                bus.rx_data      = 8'hA5;
                bus.rx_done_tick = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.rx_done_tick = 1'b0;
        end
        bus.m_ready = 1'b1;
        idle(3);
        checkOutput("bp_pkt_ok", okCnt - ok0, 1);
        checkOutput("bp_err_ovr", ovrCnt - ovr0, 1);
        checkOutput("bp_err_len", lenCnt - len0, 0);
        checkOutput("bp_sb_left", expQ.size(), 0);
        checkOutput("bp_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a payload.
        sendByte(8'hA5);
        sendByte(8'h04);
        sendByte(8'h01);
        sendByte(8'h02);
        #2 rst_n = 1'b0;
        #1;
        checkOutputsZero("rst_payload");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        applyStimulus(0);

        // Reset while a verified packet is stalled in drain.
        ok0 = okCnt;
        bus.m_ready = 1'b0;
        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h10);
        sendByte(8'h20);
        sendByte(8'h32);
        idle(2);
        checkOutput("rst_drain_ok", okCnt - ok0, 1);
        checkOutput("rst_drain_stall", {23'd0, bus.m_valid, bus.m_data}, {23'd0, 1'b1, 8'h10});
        #2 rst_n = 1'b0;
        #1;
        checkOutputsZero("rst_drain");
        idle(2);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        idle(1);
        applyStimulus(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
